// File: rtl/display_video.sv
// ============================================================================
// display_video : 320x240 raster with background colour and a D-pad cursor
// Rev 1.0
// ============================================================================
`default_nettype none

module display_video #(
  parameter int H_BPORCH   = 10,
  parameter int H_ACTIVE   = 320,
  parameter int H_TOTAL    = 400,
  parameter int V_BPORCH   = 10,
  parameter int V_ACTIVE   = 240,
  parameter int V_TOTAL    = 512,
  parameter int HS_X       = 3,
  parameter int BOX        = 16,
  parameter int BOX_X_INIT = 152,
  parameter int BOX_Y_INIT = 112
) (
  input  logic        clk_core_12288,
  input  logic        reset,
  input  logic [15:0] cont1_key,
  input  logic [31:0] bridge_addr,
  input  logic        bridge_wr,
  input  logic [31:0] bridge_wr_data,
  output logic [23:0] video_rgb,
  output logic        video_de,
  output logic        video_skip,
  output logic        video_vs,
  output logic        video_hs
);

  // One spare count value so H_TOTAL / V_TOTAL themselves are representable.
  localparam int XW = $clog2(H_TOTAL + 1);
  localparam int YW = $clog2(V_TOTAL + 1);

  localparam logic [XW-1:0] C_X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] C_Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] C_X_START  = XW'(H_BPORCH);
  localparam logic [XW-1:0] C_X_END    = XW'(H_BPORCH + H_ACTIVE);
  localparam logic [YW-1:0] C_Y_START  = YW'(V_BPORCH);
  localparam logic [YW-1:0] C_Y_END    = YW'(V_BPORCH + V_ACTIVE);
  localparam logic [XW-1:0] C_HS_X     = XW'(HS_X);
  localparam logic [XW-1:0] C_BOX_W    = XW'(BOX);
  localparam logic [YW-1:0] C_BOX_H    = YW'(BOX);
  localparam logic [XW-1:0] C_BX_MAX   = XW'(H_ACTIVE - BOX);
  localparam logic [YW-1:0] C_BY_MAX   = YW'(V_ACTIVE - BOX);
  localparam logic [XW-1:0] C_BX_INIT  = XW'(BOX_X_INIT);
  localparam logic [YW-1:0] C_BY_INIT  = YW'(BOX_Y_INIT);
  localparam logic [23:0]   C_BG_INIT  = 24'h202040;
  localparam logic [23:0]   C_BOX_INIT = 24'hFFFFFF;
  localparam logic [31:0]   C_ADDR_BG  = 32'h0000_0000;
  localparam logic [31:0]   C_ADDR_BOX = 32'h0000_0004;

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [XW-1:0] box_x_q, box_x_d;
  logic [YW-1:0] box_y_q, box_y_d;
  logic [23:0]   bg_color_q, bg_color_d;
  logic [23:0]   box_color_q, box_color_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          de_q, de_d;
  logic          vs_q, vs_d;
  logic          hs_q, hs_d;

  logic          frame_start;
  logic          h_act, v_act, in_box;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          key_up, key_down, key_left, key_right;

  assign key_up    = cont1_key[0];
  assign key_down  = cont1_key[1];
  assign key_left  = cont1_key[2];
  assign key_right = cont1_key[3];

  logic unused_ok;
  assign unused_ok = ^{bridge_wr_data[31:24], cont1_key[15:4]};

  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_q == C_X_LAST) begin
      x_d = '0;
      y_d = (y_q == C_Y_LAST) ? '0 : y_q + YW'(1);
    end

    frame_start = (x_q == '0) && (y_q == '0);
    h_act = (x_q >= C_X_START) && (x_q < C_X_END);
    v_act = (y_q >= C_Y_START) && (y_q < C_Y_END);
    // Pixel coords wrap outside the active window; in_box is only used when active.
    px = x_q - C_X_START;
    py = y_q - C_Y_START;
    in_box = (px >= box_x_q) && (px < box_x_q + C_BOX_W) &&
             (py >= box_y_q) && (py < box_y_q + C_BOX_H);

    box_x_d = box_x_q;
    box_y_d = box_y_q;
    if (frame_start) begin
      if (key_right && !key_left && (box_x_q < C_BX_MAX)) begin
        box_x_d = box_x_q + XW'(1);
      end else if (key_left && !key_right && (box_x_q != '0)) begin
        box_x_d = box_x_q - XW'(1);
      end
      if (key_down && !key_up && (box_y_q < C_BY_MAX)) begin
        box_y_d = box_y_q + YW'(1);
      end else if (key_up && !key_down && (box_y_q != '0)) begin
        box_y_d = box_y_q - YW'(1);
      end
    end

    bg_color_d  = bg_color_q;
    box_color_d = box_color_q;
    if (bridge_wr) begin
      if (bridge_addr == C_ADDR_BG) begin
        bg_color_d = bridge_wr_data[23:0];
      end else if (bridge_addr == C_ADDR_BOX) begin
        box_color_d = bridge_wr_data[23:0];
      end
    end

    de_d  = h_act && v_act;
    vs_d  = frame_start;
    hs_d  = (x_q == C_HS_X);
    rgb_d = '0;
    if (de_d) begin
      rgb_d = in_box ? box_color_q : bg_color_q;
    end
  end

  always_ff @(posedge clk_core_12288 or posedge reset) begin
    if (reset) begin
      x_q         <= '0;
      y_q         <= '0;
      box_x_q     <= C_BX_INIT;
      box_y_q     <= C_BY_INIT;
      bg_color_q  <= C_BG_INIT;
      box_color_q <= C_BOX_INIT;
      rgb_q       <= '0;
      de_q        <= 1'b0;
      vs_q        <= 1'b0;
      hs_q        <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      box_x_q     <= box_x_d;
      box_y_q     <= box_y_d;
      bg_color_q  <= bg_color_d;
      box_color_q <= box_color_d;
      rgb_q       <= rgb_d;
      de_q        <= de_d;
      vs_q        <= vs_d;
      hs_q        <= hs_d;
    end
  end

  assign video_rgb  = rgb_q;
  assign video_de   = de_q;
  assign video_vs   = vs_q;
  assign video_hs   = hs_q;
  assign video_skip = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_display_video.sv
// ============================================================================
// tb_display_video : reduced-geometry raster checked against a frame model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_display_video;

  localparam int HB = 2, HA = 20, HT = 28;
  localparam int VB = 2, VA = 12, VT = 16;
  localparam int HSX = 3, BX = 4, BX0 = 8, BY0 = 4;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] key = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        wr = 1'b0;
  logic [23:0] video_rgb;
  logic        video_de, video_skip, video_vs, video_hs;

  always #5 clk = ~clk;

  display_video #(
    .H_BPORCH(HB), .H_ACTIVE(HA), .H_TOTAL(HT),
    .V_BPORCH(VB), .V_ACTIVE(VA), .V_TOTAL(VT),
    .HS_X(HSX), .BOX(BX), .BOX_X_INIT(BX0), .BOX_Y_INIT(BY0)
  ) dut (
    .clk_core_12288(clk),
    .reset(rst),
    .cont1_key(key),
    .bridge_addr(addr),
    .bridge_wr(wr),
    .bridge_wr_data(wdata),
    .video_rgb(video_rgb),
    .video_de(video_de),
    .video_skip(video_skip),
    .video_vs(video_vs),
    .video_hs(video_hs)
  );

  typedef struct {
    int          px;
    int          py;
    logic [23:0] rgb;
  } pix_vec_t;

  typedef struct {
    logic [3:0] keys;
    int         nframes;
    int         exp_bx;
    int         exp_by;
  } cur_vec_t;

  int total = 0, bad = 0;
  int t, cyc = 0;
  int mbx, mby;
  logic [23:0] mbg, mbox;
  logic [23:0] cap [VA][HA];
  int vs_cnt, hs_cnt, de_cnt, de_lines, first_vs_t;
  int last_vs = -1, last_hs = -1;
  logic prev_de = 1'b0;
  logic [31:0] wa [3];
  logic [31:0] wd [3];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0d)", name, got, want, t);
    end
  endtask

  task automatic reset_model();
    t = 0; mbx = BX0; mby = BY0;
    mbg = 24'h202040; mbox = 24'hFFFFFF;
    last_vs = -1; last_hs = -1;
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  // One clock: expected outputs come from the raster position of the cycle
  // being clocked and the colours/cursor in force before that edge.
  task automatic tick(input logic [3:0] k, input logic w, input logic [31:0] a, input logic [31:0] d);
    int x, y, px, py;
    logic ede, evs, ehs;
    logic [23:0] ergb;
    logic [15:0] r;
    x = t % HT;
    y = (t / HT) % VT;
    px = x - HB; py = y - VB;
    ede = (x >= HB) && (x < HB + HA) && (y >= VB) && (y < VB + VA);
    evs = (x == 0) && (y == 0);
    ehs = (x == HSX);
    if (!ede) ergb = 24'h0;
    else if (px >= mbx && px < mbx + BX && py >= mby && py < mby + BX) ergb = mbox;
    else ergb = mbg;
    r = 16'($urandom);
    key = {r[15:4], k}; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (w && a == 32'h0) mbg = d[23:0];
    else if (w && a == 32'h4) mbox = d[23:0];
    if (evs) begin
      mbx = clampi(mbx + int'(k[3] && !k[2]) - int'(k[2] && !k[3]), HA - BX);
      mby = clampi(mby + int'(k[1] && !k[0]) - int'(k[0] && !k[1]), VA - BX);
    end
    check("pixel", {video_skip, video_vs, video_hs, video_de, video_rgb},
          {1'b0, evs, ehs, ede, ergb});
    if (ede) cap[py][px] = video_rgb;
    if (video_vs) begin
      if (last_vs >= 0) check("vs_period", 64'(cyc - last_vs), 64'(FRAME));
      if (vs_cnt == 0) first_vs_t = t;
      last_vs = cyc; vs_cnt++;
    end
    if (video_hs) begin
      if (last_hs >= 0) check("hs_period", 64'(cyc - last_hs), 64'(HT));
      last_hs = cyc; hs_cnt++;
    end
    if (video_de) de_cnt++;
    if (video_de && !prev_de) de_lines++;
    prev_de = video_de;
    t++; cyc++;
    wr = 1'b0;
  endtask

  task automatic run_frame(input logic [3:0] k, input int nw);
    for (int py = 0; py < VA; py++)
      for (int px = 0; px < HA; px++) cap[py][px] = 24'h0;
    vs_cnt = 0; hs_cnt = 0; de_cnt = 0; de_lines = 0; first_vs_t = -1;
    for (int i = 0; i < FRAME; i++) begin
      if (i < nw) tick((i == 0) ? k : 4'($urandom), 1'b1, wa[i], wd[i]);
      else        tick((i == 0) ? k : 4'($urandom), 1'b0, 32'h0, 32'h0);
    end
    check("frame_vs_count", 64'(vs_cnt), 64'd1);
    check("frame_hs_count", 64'(hs_cnt), 64'(VT));
    check("frame_de_count", 64'(de_cnt), 64'(HA * VA));
    check("frame_de_lines", 64'(de_lines), 64'(VA));
  endtask

  task automatic find_box(input logic [23:0] col, output int bx, output int by);
    bx = -1; by = -1;
    for (int py = 0; py < VA; py++)
      for (int px = 0; px < HA; px++)
        if (bx < 0 && cap[py][px] === col) begin bx = px; by = py; end
  endtask

  pix_vec_t pix_tab [6];
  cur_vec_t cur_tab [10];

  initial begin
    int bx, by;
    pix_tab[0] = '{0,        0,            24'h202040};
    pix_tab[1] = '{BX0,      BY0,          24'hFFFFFF};
    pix_tab[2] = '{BX0 + BX, BY0,          24'h202040};
    pix_tab[3] = '{BX0+BX-1, BY0 + BX - 1, 24'hFFFFFF};
    pix_tab[4] = '{BX0 - 1,  BY0,          24'h202040};
    pix_tab[5] = '{HA - 1,   VA - 1,       24'h202040};

    cur_tab[0] = '{4'b0000, 1,  8,  4};
    cur_tab[1] = '{4'b1010, 1,  9,  5};
    cur_tab[2] = '{4'b1000, 12, 16, 5};
    cur_tab[3] = '{4'b0001, 8,  16, 0};
    cur_tab[4] = '{4'b0010, 2,  16, 2};
    cur_tab[5] = '{4'b0011, 3,  16, 2};
    cur_tab[6] = '{4'b1100, 2,  16, 2};
    cur_tab[7] = '{4'b0100, 3,  13, 2};
    cur_tab[8] = '{4'b0010, 15, 13, 8};
    cur_tab[9] = '{4'b0101, 1,  12, 7};

    reset_model();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_outputs", {video_skip, video_vs, video_hs, video_de, video_rgb}, 64'h0);
    end
    rst = 1'b0;

    run_frame(4'b0000, 0);
    check("first_vs_at_origin", 64'(first_vs_t), 64'd0);
    for (int i = 0; i < 6; i++)
      check("first_frame_pixel", cap[pix_tab[i].py][pix_tab[i].px], pix_tab[i].rgb);

    wa[0] = 32'h0; wd[0] = 32'h00FF0000;
    wa[1] = 32'h4; wd[1] = 32'h0000FF00;
    wa[2] = 32'h8; wd[2] = 32'h00123456;
    run_frame(4'b0000, 3);
    check("bridge_bg", cap[0][0], 24'hFF0000);
    check("bridge_box", cap[BY0][BX0], 24'h00FF00);
    check("bridge_addr8_ignored", cap[VA-1][HA-1], 24'hFF0000);

    for (int i = 0; i < 10; i++) begin
      for (int f = 0; f < cur_tab[i].nframes; f++) run_frame(cur_tab[i].keys, 0);
      find_box(24'h00FF00, bx, by);
      check("cursor_pos", {32'(bx), 32'(by)}, {32'(cur_tab[i].exp_bx), 32'(cur_tab[i].exp_by)});
      if (i == 2) check("right_edge_pixel", cap[5][HA-1], 24'h00FF00);
    end

    for (int i = 0; i < HT * 5 + 7; i++) tick(4'b0000, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {video_skip, video_vs, video_hs, video_de, video_rgb}, 64'h0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("reset_hold_outputs", {video_skip, video_vs, video_hs, video_de, video_rgb}, 64'h0);
    end
    rst = 1'b0;
    reset_model();
    run_frame(4'b0000, 0);
    check("vs_after_reset", 64'(first_vs_t), 64'd0);
    find_box(24'hFFFFFF, bx, by);
    check("cursor_after_reset", {32'(bx), 32'(by)}, {32'(BX0), 32'(BY0)});
    check("bg_after_reset", cap[0][0], 24'h202040);

    for (int i = 0; i < 5 * FRAME; i++) begin
      logic [31:0] ra;
      case ($urandom % 4)
        0: ra = 32'h0;
        1: ra = 32'h4;
        2: ra = 32'h8;
        default: ra = $urandom;
      endcase
      tick(4'($urandom), ($urandom % 8) == 0, ra, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
